result_streamer: RTL and testbench

//  Downstream stage of the SMVM row-accumulator pipeline. Waits for the accumulator's done

---
 rtl/result_streamer_pkg.sv | 27 ++
 rtl/result_streamer_if.sv | 9 +
 rtl/result_streamer_word_serializer.sv | 45 ++++
 rtl/result_streamer.sv | 130 +++++++++++++
 tb/tb_result_streamer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/result_streamer_pkg.sv
// Shared types and helpers for the SMVM result streaming stage.
// The frame FSM states, default sizing and the checksum trailer helper live here.
package result_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        FIN  = 3'd4
    } stream_state_t;

    localparam int DEFAULT_MATRIX_SIZE = 128;
    localparam int DEFAULT_WORD_W      = 32;
    localparam int BYTES_PER_WORD      = DEFAULT_WORD_W / 8;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Two's-complement trailer: makes the byte sum of the whole frame 0 mod 256.
    function automatic logic [7:0] csum_trailer(input logic [7:0] sum);
        return ~sum + 8'd1;
    endfunction

endpackage

// File: rtl/result_streamer_if.sv
// Byte stream with valid/ready handshake from the result streamer to the host link.
interface result_streamer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/result_streamer_word_serializer.sv
// Holds one accumulator word and steps through it LSB byte first.
// next_byte is the byte that follows the one currently on the stream.
module result_streamer_word_serializer
    import result_streamer_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              load,
    input  logic              advance,
    input  logic [WORD_W-1:0] word,
    output logic [7:0]        next_byte,
    output logic              last_byte
);

    localparam int BPW = WORD_W / 8;
    localparam int BIW = idx_width(BPW);

    logic [WORD_W-1:0] shreg_r;
    logic [WORD_W-1:0] shifted_s;
    logic [BIW-1:0]    byte_idx_r;

    assign shifted_s = shreg_r >> 4'd8;
    assign next_byte = shifted_s[7:0];
    assign last_byte = (byte_idx_r == BIW'(BPW - 1));

    // Shift register and byte position within the current word.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            shreg_r    <= '0;
            byte_idx_r <= '0;
        end else if (load) begin
            shreg_r    <= word;
            byte_idx_r <= '0;
        end else if (advance) begin
            shreg_r    <= shifted_s;
            byte_idx_r <= last_byte ? '0 : byte_idx_r + BIW'(1);
        end else begin
            shreg_r    <= shreg_r;
            byte_idx_r <= byte_idx_r;
        end
    end

endmodule

// File: rtl/result_streamer.sv
// Streams a finished accumulator vector as bytes plus a checksum trailer,
// once per rising edge of done.
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
    parameter int WORD_W      = DEFAULT_WORD_W
) (
    input  logic                               clk,
    input  logic                               rst_l,
    input  logic [MATRIX_SIZE-1:0][WORD_W-1:0] accum,
    input  logic                               done,
    result_streamer_if.master                  strm,
    output logic                               busy,
    output logic                               finished
);

    localparam int WIW = idx_width(MATRIX_SIZE);

    stream_state_t     state_r;
    logic [WIW-1:0]    word_idx_r;
    logic [7:0]        csum_r;
    logic [7:0]        out_data_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              finished_r;
    logic              done_q_r;

    logic              trigger_s;
    logic              accept_s;
    logic              load_s;
    logic              advance_s;
    logic              last_byte_s;
    logic              last_word_s;
    logic [7:0]        csum_next_s;
    logic [7:0]        next_byte_s;
    logic [WORD_W-1:0] word_sel_s;

    assign trigger_s   = done & ~done_q_r;
    assign accept_s    = out_valid_r & strm.out_ready;
    assign load_s      = (state_r == LOAD);
    assign advance_s   = (state_r == SEND) & accept_s;
    assign last_word_s = (word_idx_r == WIW'(MATRIX_SIZE - 1));
    assign csum_next_s = csum_r + out_data_r;
    assign word_sel_s  = accum[word_idx_r];

    result_streamer_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk       (clk),
        .rst_l     (rst_l),
        .load      (load_s),
        .advance   (advance_s),
        .word      (word_sel_s),
        .next_byte (next_byte_s),
        .last_byte (last_byte_s)
    );

    // Frame sequencing; out_data/out_valid are registered and only move on accept.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r     <= IDLE;
            word_idx_r  <= '0;
            csum_r      <= 8'd0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            finished_r  <= 1'b0;
            done_q_r    <= 1'b0;
        end else begin
            done_q_r <= done;
            case (state_r)
                IDLE: begin
                    if (trigger_s) begin
                        state_r    <= LOAD;
                        word_idx_r <= '0;
                        csum_r     <= 8'd0;
                        busy_r     <= 1'b1;
                        finished_r <= 1'b0;
                    end
                end
                LOAD: begin
                    out_data_r  <= word_sel_s[7:0];
                    out_valid_r <= 1'b1;
                    state_r     <= SEND;
                end
                SEND: begin
                    if (accept_s) begin
                        csum_r <= csum_next_s;
                        if (last_byte_s && last_word_s) begin
                            state_r    <= CSUM;
                            out_data_r <= csum_trailer(csum_next_s);
                        end else if (last_byte_s) begin
                            // one bubble cycle per word while the next word loads
                            state_r     <= LOAD;
                            word_idx_r  <= word_idx_r + WIW'(1);
                            out_valid_r <= 1'b0;
                        end else begin
                            out_data_r <= next_byte_s;
                        end
                    end
                end
                CSUM: begin
                    if (accept_s) begin
                        state_r     <= FIN;
                        out_valid_r <= 1'b0;
                        out_data_r  <= 8'd0;
                        busy_r      <= 1'b0;
                        finished_r  <= 1'b1;
                    end
                end
                FIN: begin
                    // re-arm only once done has dropped; finished stays set
                    if (!done) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign strm.out_data  = out_data_r;
    assign strm.out_valid = out_valid_r;
    assign busy           = busy_r;
    assign finished       = finished_r;

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: default-size DUT plus a 4x16-bit instance,
// expected frames come from a byte-list model of the accumulator contents.
module tb_result_streamer;
    import result_streamer_pkg::*;

    localparam int MS_B   = 128;
    localparam int WW_B   = 32;
    localparam int MS_S   = 4;
    localparam int WW_S   = 16;
    localparam int BUDGET = 8000;

    logic clk;
    logic rst_l;
    logic done_b;
    logic done_s;
    logic ready_drv;
    logic sel;
    logic [MS_B-1:0][WW_B-1:0] accum_b;
    logic [MS_S-1:0][WW_S-1:0] accum_s;
    logic busy_b, fin_b, busy_s, fin_s;
    logic [7:0] mon_data;
    logic mon_valid, mon_busy, mon_fin;

    int checks   = 0;
    int failures = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    result_streamer_if big_if();
    result_streamer_if small_if();

    assign big_if.out_ready   = ready_drv;
    assign small_if.out_ready = ready_drv;

    result_streamer #(.MATRIX_SIZE(MS_B), .WORD_W(WW_B)) dut_b (
        .clk(clk), .rst_l(rst_l), .accum(accum_b), .done(done_b),
        .strm(big_if.master), .busy(busy_b), .finished(fin_b));

    result_streamer #(.MATRIX_SIZE(MS_S), .WORD_W(WW_S)) dut_s (
        .clk(clk), .rst_l(rst_l), .accum(accum_s), .done(done_s),
        .strm(small_if.master), .busy(busy_s), .finished(fin_s));

    assign mon_data  = sel ? small_if.out_data  : big_if.out_data;
    assign mon_valid = sel ? small_if.out_valid : big_if.out_valid;
    assign mon_busy  = sel ? busy_s : busy_b;
    assign mon_fin   = sel ? fin_s  : fin_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          pattern;
        int          ready_pct;
        bit          use_const;
        logic [63:0] first8;
        logic [7:0]  trailer;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic set_done(input logic v);
        if (sel) done_s = v;
        else     done_b = v;
    endtask

    task automatic set_pattern(input int pattern);
        for (int i = 0; i < MS_B; i++) begin
            case (pattern)
                0:       accum_b[i] = 32'(i);
                1:       accum_b[i] = (i == 0) ? 32'hDEADBEEF : 32'h0;
                default: accum_b[i] = $urandom();
            endcase
        end
    endtask

    // Reference: words ascending, bytes LSB first, trailer makes the byte sum 0 mod 256.
    task automatic build_expected();
        int sum = 0;
        int nw  = sel ? MS_S : MS_B;
        int nb  = sel ? WW_S / 8 : WW_B / 8;
        logic [31:0] w;
        logic [7:0]  bt;
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            w = sel ? 32'(accum_s[i]) : accum_b[i];
            for (int b = 0; b < nb; b++) begin
                bt = 8'((w >> (8 * b)) & 32'hFF);
                exp_q.push_back(bt);
                sum += int'(bt);
            end
        end
        exp_q.push_back(8'((256 - (sum % 256)) % 256));
    endtask

    task automatic run_frame(input int ready_pct, input int abort_at, input int drop_at,
                             output bit aborted);
        bit stalled = 1'b0;
        bit ended   = 1'b0;
        logic [7:0] held = 8'd0;
        got_q.delete();
        aborted = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !ended && !aborted; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                check("stall_valid_held", {63'd0, mon_valid}, 64'd1);
                check("stall_data_held", {56'd0, mon_data}, {56'd0, held});
            end
            if (mon_fin && !mon_busy && got_q.size() > 0) begin
                ended = 1'b1;
            end else if (abort_at >= 0 && got_q.size() == abort_at) begin
                rst_l = 1'b0;
                #1;
                check("abort_data",     {56'd0, mon_data},  64'd0);
                check("abort_valid",    {63'd0, mon_valid}, 64'd0);
                check("abort_busy",     {63'd0, mon_busy},  64'd0);
                check("abort_finished", {63'd0, mon_fin},   64'd0);
                aborted = 1'b1;
            end else begin
                ready_drv = ($urandom_range(99) < ready_pct);
                if (mon_valid && ready_drv) begin
                    got_q.push_back(mon_data);
                    if (drop_at >= 0 && got_q.size() == drop_at) set_done(1'b0);
                end
                stalled = mon_valid && !ready_drv;
                held    = mon_data;
            end
        end
        if (!ended && !aborted) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got %0d bytes, frame never finished", got_q.size());
        end
    endtask

    task automatic compare_frame(input string name);
        int bad = -1;
        int sum = 0;
        build_expected();
        check({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s_bytes: first difference at byte %0d got 0x%0h want 0x%0h", name, bad,
                     (bad < got_q.size()) ? got_q[bad] : 8'h00, exp_q[bad]);
        end
        foreach (got_q[i]) sum += int'(got_q[i]);
        check({name, "_sum0"}, 64'(sum % 256), 64'd0);
        check({name, "_finished"}, {63'd0, mon_fin},   64'd1);
        check({name, "_busy"},     {63'd0, mon_busy},  64'd0);
        check({name, "_valid"},    {63'd0, mon_valid}, 64'd0);
    endtask

    initial begin
        bit ab;
        bit seen;
        logic [63:0] f8;
        logic [7:0] exp_small[9];

        rst_l = 1'b0; done_b = 1'b0; done_s = 1'b0; ready_drv = 1'b0; sel = 1'b0;
        accum_b = '0; accum_s = '0;

        // DEADBEEF bytes sum to 0x38, ramp 0..127 sums to 0xC0.
        vecs[0] = '{"ramp",       0, 100, 1'b1, 64'h00000001_00000000, 8'h40};
        vecs[1] = '{"deadbeef",   1, 100, 1'b1, 64'h00000000_DEADBEEF, 8'hC8};
        vecs[2] = '{"ramp_stall", 0, 30,  1'b1, 64'h00000001_00000000, 8'h40};
        vecs[3] = '{"random",     2, 45,  1'b0, 64'h0, 8'h00};
        exp_small = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00, 8'h01, 8'h80, 8'hC2};

        #12;
        check("rst_data",     {56'd0, mon_data},  64'd0);
        check("rst_valid",    {63'd0, mon_valid}, 64'd0);
        check("rst_busy",     {63'd0, mon_busy},  64'd0);
        check("rst_finished", {63'd0, mon_fin},   64'd0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy",  {63'd0, mon_busy},  64'd0);
        check("idle_valid", {63'd0, mon_valid}, 64'd0);

        for (int r = 0; r < 4; r++) begin
            set_pattern(vecs[r].pattern);
            repeat (2) @(negedge clk);
            done_b = 1'b1;
            run_frame(vecs[r].ready_pct, -1, -1, ab);
            compare_frame(vecs[r].name);
            if (vecs[r].use_const && got_q.size() >= 8) begin
                f8 = {got_q[7], got_q[6], got_q[5], got_q[4], got_q[3], got_q[2], got_q[1], got_q[0]};
                check({vecs[r].name, "_first8"}, f8, vecs[r].first8);
                check({vecs[r].name, "_trailer"}, {56'd0, got_q[got_q.size() - 1]},
                      {56'd0, vecs[r].trailer});
            end
            done_b = 1'b0;
        end

        // done held high after finishing must not start another frame
        set_pattern(0);
        repeat (2) @(negedge clk);
        done_b = 1'b1;
        run_frame(100, -1, -1, ab);
        compare_frame("hold1");
        seen = 1'b0;
        ready_drv = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (mon_valid || mon_busy || !mon_fin) seen = 1'b1;
        end
        check("hold_no_retrigger", {63'd0, seen}, 64'd0);
        done_b = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_finished_sticky", {63'd0, mon_fin}, 64'd1);
        done_b = 1'b1;
        @(negedge clk);
        check("retrigger_fin_clear", {63'd0, mon_fin},  64'd0);
        check("retrigger_busy",      {63'd0, mon_busy}, 64'd1);
        run_frame(70, -1, 100, ab);
        compare_frame("hold2_done_drop");

        // reset in the middle of a frame, then a fresh frame from word 0
        repeat (2) @(negedge clk);
        done_b = 1'b1;
        run_frame(100, 200, -1, ab);
        repeat (2) @(negedge clk);
        check("in_reset_valid", {63'd0, mon_valid}, 64'd0);
        rst_l = 1'b1;
        run_frame(100, -1, -1, ab);
        compare_frame("after_reset");
        done_b = 1'b0;

        // small instance: 4 words of 16 bits, 9-byte frame
        sel = 1'b1;
        accum_s = {16'h8001, 16'h00FF, 16'hABCD, 16'h1234};
        repeat (2) @(negedge clk);
        done_s = 1'b1;
        run_frame(50, -1, -1, ab);
        compare_frame("small");
        for (int i = 0; i < 9; i++) begin
            check($sformatf("small_byte%0d", i),
                  {56'd0, (i < got_q.size()) ? got_q[i] : 8'hxx}, {56'd0, exp_small[i]});
        end
        done_s = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
